// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline stage register family.
//
// Contents:
//   CTRL_REGWRITE / CTRL_MEMTOREG : bit positions inside the control bundle
//   DEF_RD_W / DEF_CTRL_W         : default destination-index / ctrl widths
//   ctrl_t                        : named view of the default 2-bit ctrl bundle
//   occ_count()                   : occupancy from the two slot valid bits
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;

    localparam int unsigned DEF_RD_W      = 5;
    localparam int unsigned DEF_CTRL_W    = 2;

    // Field order matches the bit indices above (memtoreg is the MSB).
    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } ctrl_t;

    function automatic logic [1:0] occ_count(input logic main_valid,
                                             input logic skid_valid);
        return {1'b0, main_valid} + {1'b0, skid_valid};
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// -----------------------------------------------------------------------------
// pipe_entry_reg
// One storage slot of the elastic stage: a valid bit plus the payload
// (destination index, read data, ALU result, control bundle).
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset, clears valid and payload
//   load_i       in   capture the payload inputs and mark the slot valid
//   kill_i       in   mark the slot invalid, payload holds its last value
//   clr_i        in   squash: clear valid and ctrl (highest priority)
//   rd_i         in   destination register index to capture
//   read_data_i  in   memory read data to capture
//   alu_res_i    in   ALU result to capture
//   ctrl_i       in   control bundle to capture
//   valid_o      out  slot holds a live entry
//   rd_o         out  stored destination register index
//   read_data_o  out  stored read data
//   alu_res_o    out  stored ALU result
//   ctrl_o       out  stored control bundle (unmasked)
// -----------------------------------------------------------------------------
module pipe_entry_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned CTRL_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              kill_i,
    input  logic              clr_i,
    input  logic [RD_W-1:0]   rd_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] alu_res_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [RD_W-1:0]   rd_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] alu_res_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q,     valid_d;
    logic [RD_W-1:0]   rd_q,        rd_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [DATA_W-1:0] alu_res_q,   alu_res_d;
    logic [CTRL_W-1:0] ctrl_q,      ctrl_d;

    // Squash only touches valid and ctrl; data fields are left as they were
    // since nothing downstream may use them without a valid slot.
    always_comb begin
        valid_d     = valid_q;
        rd_d        = rd_q;
        read_data_d = read_data_q;
        alu_res_d   = alu_res_q;
        ctrl_d      = ctrl_q;
        if (clr_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d     = 1'b1;
            rd_d        = rd_i;
            read_data_d = read_data_i;
            alu_res_d   = alu_res_i;
            ctrl_d      = ctrl_i;
        end else if (kill_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rd_q        <= '0;
            read_data_q <= '0;
            alu_res_q   <= '0;
            ctrl_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            read_data_q <= read_data_d;
            alu_res_q   <= alu_res_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign valid_o     = valid_q;
    assign rd_o        = rd_q;
    assign read_data_o = read_data_q;
    assign alu_res_o   = alu_res_q;
    assign ctrl_o      = ctrl_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
// Generic elastic pipeline stage register (usable at any boundary from IF/ID
// to MEM/WB) with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush, bubble-safe control gating and a writeback-data mux.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   flush          in   synchronous squash of all held entries
//   in_valid       in   upstream entry valid
//   in_ready       out  stage can accept this cycle
//   in_rd          in   destination register index
//   in_read_data   in   memory read data
//   in_alu_res     in   ALU result
//   in_ctrl        in   control bundle (bit0 RegWrite, bit1 MemtoReg)
//   out_valid      out  head entry valid
//   out_ready      in   downstream accepts the head
//   out_rd         out  head destination register index
//   out_read_data  out  head read data
//   out_alu_res    out  head ALU result
//   out_ctrl       out  head control, forced to 0 for an invalid head
//   wb_data        out  head read data if MemtoReg else head ALU result
//   occupancy      out  number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned RD_W         = DEF_RD_W,
    parameter int unsigned CTRL_W       = DEF_CTRL_W,
    parameter int unsigned MEMTOREG_BIT = CTRL_MEMTOREG,
    parameter int unsigned SKID_EN      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_read_data,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        occupancy
);

    // Main (head) slot
    logic              main_valid;
    logic [RD_W-1:0]   main_rd;
    logic [DATA_W-1:0] main_read_data;
    logic [DATA_W-1:0] main_alu_res;
    logic [CTRL_W-1:0] main_ctrl;
    logic              main_load, main_kill;

    // Skid slot
    logic              skid_valid;
    logic [RD_W-1:0]   skid_rd;
    logic [DATA_W-1:0] skid_read_data;
    logic [DATA_W-1:0] skid_alu_res;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              skid_load, skid_kill;

    // Main slot input mux: refilled from skid on a pop, otherwise from upstream
    logic              main_from_skid;
    logic [RD_W-1:0]   main_rd_in;
    logic [DATA_W-1:0] main_read_data_in;
    logic [DATA_W-1:0] main_alu_res_in;
    logic [CTRL_W-1:0] main_ctrl_in;

    logic accept;
    logic pop;

    // With the skid buffer, in_ready depends only on a flop, so back-pressure
    // never forms a combinational path from out_ready to in_ready.
    assign in_ready = (SKID_EN != 0) ? ~skid_valid
                                     : (out_ready | ~main_valid);

    assign accept = in_valid  & in_ready;
    assign pop    = main_valid & out_ready;

    always_comb begin
        main_load      = 1'b0;
        main_kill      = 1'b0;
        skid_load      = 1'b0;
        skid_kill      = 1'b0;
        main_from_skid = 1'b0;
        if (SKID_EN != 0) begin
            if (pop) begin
                if (skid_valid) begin
                    // in_ready is low here, so no accept can coincide
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_kill      = 1'b1;
                end else if (accept) begin
                    main_load = 1'b1;
                end else begin
                    main_kill = 1'b1;
                end
            end else if (accept) begin
                if (!main_valid) begin
                    main_load = 1'b1;
                end else begin
                    skid_load = 1'b1;
                end
            end
        end else begin
            if (accept) begin
                main_load = 1'b1;
            end else if (pop) begin
                main_kill = 1'b1;
            end
        end
    end

    always_comb begin
        main_rd_in        = in_rd;
        main_read_data_in = in_read_data;
        main_alu_res_in   = in_alu_res;
        main_ctrl_in      = in_ctrl;
        if (main_from_skid) begin
            main_rd_in        = skid_rd;
            main_read_data_in = skid_read_data;
            main_alu_res_in   = skid_alu_res;
            main_ctrl_in      = skid_ctrl;
        end
    end

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk         (clk),
        .reset       (reset),
        .load_i      (main_load),
        .kill_i      (main_kill),
        .clr_i       (flush),
        .rd_i        (main_rd_in),
        .read_data_i (main_read_data_in),
        .alu_res_i   (main_alu_res_in),
        .ctrl_i      (main_ctrl_in),
        .valid_o     (main_valid),
        .rd_o        (main_rd),
        .read_data_o (main_read_data),
        .alu_res_o   (main_alu_res),
        .ctrl_o      (main_ctrl)
    );

    // In the single-register build the skid slot never loads and stays empty.
    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .load_i      (skid_load),
        .kill_i      (skid_kill),
        .clr_i       (flush),
        .rd_i        (in_rd),
        .read_data_i (in_read_data),
        .alu_res_i   (in_alu_res),
        .ctrl_i      (in_ctrl),
        .valid_o     (skid_valid),
        .rd_o        (skid_rd),
        .read_data_o (skid_read_data),
        .alu_res_o   (skid_alu_res),
        .ctrl_o      (skid_ctrl)
    );

    assign out_valid     = main_valid;
    assign out_rd        = main_rd;
    assign out_read_data = main_read_data;
    assign out_alu_res   = main_alu_res;

    // Bubble safety: an invalid head can never present RegWrite/MemtoReg
    assign out_ctrl = main_ctrl & {CTRL_W{main_valid}};

    assign wb_data   = out_ctrl[MEMTOREG_BIT] ? main_read_data : main_alu_res;
    assign occupancy = occ_count(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic [63:0] alu;
        logic [1:0]  ctrl;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // sel=1 drives the skid build, sel=0 the single-register build
    logic        sel;
    logic        drv_valid, drv_out_ready, drv_flush;
    logic [4:0]  drv_rd;
    logic [63:0] drv_rdata, drv_alu;
    logic [1:0]  drv_ctrl;

    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [4:0]  out_rd1, out_rd0;
    logic [63:0] out_rdata1, out_alu1, wb1, out_rdata0, out_alu0, wb0;
    logic [1:0]  out_ctrl1, occ1, out_ctrl0, occ0;

    pipe_stage_elastic #(.DATA_W(64), .RD_W(5), .CTRL_W(2), .MEMTOREG_BIT(1), .SKID_EN(1)) dut_skid (
        .clk(clk), .reset(reset), .flush(sel & drv_flush),
        .in_valid(sel & drv_valid), .in_ready(in_ready1),
        .in_rd(drv_rd), .in_read_data(drv_rdata), .in_alu_res(drv_alu), .in_ctrl(drv_ctrl),
        .out_valid(out_valid1), .out_ready(sel & drv_out_ready),
        .out_rd(out_rd1), .out_read_data(out_rdata1), .out_alu_res(out_alu1),
        .out_ctrl(out_ctrl1), .wb_data(wb1), .occupancy(occ1)
    );

    pipe_stage_elastic #(.DATA_W(64), .RD_W(5), .CTRL_W(2), .MEMTOREG_BIT(1), .SKID_EN(0)) dut_single (
        .clk(clk), .reset(reset), .flush(~sel & drv_flush),
        .in_valid(~sel & drv_valid), .in_ready(in_ready0),
        .in_rd(drv_rd), .in_read_data(drv_rdata), .in_alu_res(drv_alu), .in_ctrl(drv_ctrl),
        .out_valid(out_valid0), .out_ready(~sel & drv_out_ready),
        .out_rd(out_rd0), .out_read_data(out_rdata0), .out_alu_res(out_alu0),
        .out_ctrl(out_ctrl0), .wb_data(wb0), .occupancy(occ0)
    );

    logic        o_ready, o_valid;
    logic [4:0]  o_rd;
    logic [63:0] o_rdata, o_alu, o_wb;
    logic [1:0]  o_ctrl, o_occ;
    assign o_ready = sel ? in_ready1  : in_ready0;
    assign o_valid = sel ? out_valid1 : out_valid0;
    assign o_rd    = sel ? out_rd1    : out_rd0;
    assign o_rdata = sel ? out_rdata1 : out_rdata0;
    assign o_alu   = sel ? out_alu1   : out_alu0;
    assign o_wb    = sel ? wb1        : wb0;
    assign o_ctrl  = sel ? out_ctrl1  : out_ctrl0;
    assign o_occ   = sel ? occ1       : occ0;

    int unsigned total = 0;
    int unsigned bad   = 0;
    ent_t        q[$];
    logic        stalled;
    logic        last_acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s sel=%0d t=%0t got=%h exp=%h", tag, sel, $time, got, exp);
        end
    endtask

    // Upstream must hold in_valid and payload while stalled (flush releases it)
    logic       p_stall, p_flush;
    ent_t       p_ent;
    always @(posedge clk) begin
        if (!reset && p_stall && !p_flush) begin
            assert (drv_valid && ent_t'{drv_rd, drv_rdata, drv_alu, drv_ctrl} == p_ent)
            else $error("FAIL hold_stable t=%0t", $time);
        end
        p_stall <= drv_valid && !o_ready;
        p_flush <= drv_flush;
        p_ent   <= ent_t'{drv_rd, drv_rdata, drv_alu, drv_ctrl};
    end

    task automatic check_zero(input string tag);
        check_eq({tag, "_valid"}, 64'(o_valid), 64'd0);
        check_eq({tag, "_ready"}, 64'(o_ready), 64'd1);
        check_eq({tag, "_occ"},   64'(o_occ),   64'd0);
        check_eq({tag, "_rd"},    64'(o_rd),    64'd0);
        check_eq({tag, "_rdata"}, o_rdata,      64'd0);
        check_eq({tag, "_alu"},   o_alu,        64'd0);
        check_eq({tag, "_ctrl"},  64'(o_ctrl),  64'd0);
        check_eq({tag, "_wb"},    o_wb,         64'd0);
    endtask

    task automatic idle();
        drv_valid = 1'b0; drv_flush = 1'b0;
    endtask

    task automatic put(input logic [4:0] rd, input logic [63:0] rdata,
                       input logic [63:0] alu, input logic [1:0] ctrl);
        drv_valid = 1'b1; drv_rd = rd; drv_rdata = rdata; drv_alu = alu; drv_ctrl = ctrl;
    endtask

    // Called at posedge+1; asserts reset between edges and checks outputs before any edge
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        idle();
        drv_out_ready = 1'b0;
        #1;
        check_zero(tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        q.delete();
        stalled = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One clock: check outputs against the queue model, then apply the edge
    task automatic cycle();
        logic exp_ready, acc, pp;
        ent_t cur, h;
        @(negedge clk);
        exp_ready = sel ? (q.size() < 2) : (drv_out_ready || q.size() == 0);
        check_eq("in_ready",  64'(o_ready), 64'(exp_ready));
        check_eq("out_valid", 64'(o_valid), 64'(q.size() != 0));
        check_eq("occupancy", 64'(o_occ),   64'(q.size()));
        if (q.size() != 0) begin
            h = q[0];
            check_eq("out_rd",    64'(o_rd),   64'(h.rd));
            check_eq("out_rdata", o_rdata,     h.rdata);
            check_eq("out_alu",   o_alu,       h.alu);
            check_eq("out_ctrl",  64'(o_ctrl), 64'(h.ctrl));
            check_eq("wb_data",   o_wb,        h.ctrl[CTRL_MEMTOREG] ? h.rdata : h.alu);
        end else begin
            check_eq("bubble_ctrl", 64'(o_ctrl), 64'd0);
        end
        acc = drv_valid && exp_ready;
        pp  = (q.size() != 0) && drv_out_ready;
        cur = '{drv_rd, drv_rdata, drv_alu, drv_ctrl};
        @(posedge clk);
        #1;
        if (drv_flush) begin
            q.delete();
        end else begin
            if (pp)  void'(q.pop_front());
            if (acc) q.push_back(cur);
        end
        last_acc = acc;
        stalled  = drv_valid && !acc && !drv_flush;
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            if (!stalled) begin
                drv_valid = ($urandom_range(0, 3) != 0);
                drv_rd    = 5'($urandom);
                drv_rdata = {$urandom, $urandom};
                drv_alu   = {$urandom, $urandom};
                drv_ctrl  = 2'($urandom);
            end
            drv_out_ready = ($urandom_range(0, 2) != 0);
            drv_flush     = ($urandom_range(0, 15) == 0);
            cycle();
        end
        idle();
        drv_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
    endtask

    initial begin
        reset = 1'b1; sel = 1'b1; stalled = 1'b0; last_acc = 1'b0;
        p_stall = 1'b0; p_flush = 1'b0; p_ent = '0;
        drv_valid = 1'b0; drv_out_ready = 1'b0; drv_flush = 1'b0;
        drv_rd = '0; drv_rdata = '0; drv_alu = '0; drv_ctrl = '0;

        // ---------------- skid build ----------------
        do_reset("rst_skid");

        // streaming rd=1..4
        drv_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            put(5'(i), 64'(i * 3), 64'(i * 16), 2'b01);
            cycle();
        end
        idle();
        for (int i = 0; i < 2; i++) cycle();

        // back-pressure: 7, 8 held, 9 stalls then follows
        drv_out_ready = 1'b0;
        put(5'd7, 64'h70, 64'h700, 2'b01); cycle();
        put(5'd8, 64'h80, 64'h800, 2'b11); cycle();
        put(5'd9, 64'h90, 64'h900, 2'b01); cycle();
        cycle();
        drv_out_ready = 1'b1;
        last_acc = 1'b0;
        for (int k = 0; k < 8 && !last_acc; k++) cycle();
        check_eq("acc_rd9", 64'(last_acc), 64'd1);
        idle();
        for (int i = 0; i < 4; i++) cycle();

        // flush with full skid and a concurrent input rd=5
        drv_out_ready = 1'b0;
        put(5'd1, 64'h11, 64'h111, 2'b11); cycle();
        put(5'd2, 64'h22, 64'h222, 2'b01); cycle();
        put(5'd5, 64'h55, 64'h555, 2'b01);
        drv_flush = 1'b1;
        cycle();
        idle();
        drv_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // wb_data mux
        put(5'd3, 64'hAAAA, 64'h5555, 2'b11); cycle();
        put(5'd4, 64'hAAAA, 64'h5555, 2'b01); cycle();
        idle();
        for (int i = 0; i < 2; i++) cycle();

        // asynchronous reset mid-stream with two entries held
        drv_out_ready = 1'b0;
        put(5'd12, 64'hC, 64'hCC, 2'b11); cycle();
        put(5'd13, 64'hD, 64'hDD, 2'b11); cycle();
        idle();
        cycle();
        do_reset("rst_mid");

        rand_phase(400);

        // ---------------- single-register build ----------------
        sel = 1'b0;
        do_reset("rst_single");
        drv_out_ready = 1'b0;
        put(5'd11, 64'hB1, 64'hB11, 2'b01); cycle();
        idle();
        cycle();
        put(5'd12, 64'hB2, 64'hB22, 2'b11); cycle();
        drv_out_ready = 1'b1;
        cycle();
        check_eq("same_cycle_acc", 64'(last_acc), 64'd1);
        idle();
        for (int i = 0; i < 3; i++) cycle();

        rand_phase(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
